// File: rtl/id_ex_pipeline_reg_pkg.sv
// Shared definitions for the ID/EX pipeline register: control-bundle field
// offsets (also used by the control unit and EX/MEM register) and the per-cycle action.
package id_ex_pipeline_reg_pkg;

  localparam int CTRL_BITS_DEF   = 16;

  // Bit offsets of the decoded control bundle
  localparam int CTRL_REG_WRITE  = 0;
  localparam int CTRL_MEM_READ   = 1;
  localparam int CTRL_MEM_WRITE  = 2;
  localparam int CTRL_MEM_TO_REG = 3;
  localparam int CTRL_ALU_SRC    = 4;
  localparam int CTRL_REG_DST    = 5;
  localparam int CTRL_ALU_OP_LSB = 6;
  localparam int CTRL_ALU_OP_W   = 3;
  localparam int CTRL_BRANCH     = 9;

  typedef enum logic [1:0] {
    ACT_FREEZE = 2'd0,
    ACT_FLUSH  = 2'd1,
    ACT_STALL  = 2'd2,
    ACT_LOAD   = 2'd3
  } id_ex_action_e;

  // Priority below reset: freeze > flush > stall > load
  function automatic id_ex_action_e select_action(input logic enable,
                                                  input logic flush,
                                                  input logic stall);
    id_ex_action_e act;
    if (!enable) begin
      act = ACT_FREEZE;
    end else if (flush) begin
      act = ACT_FLUSH;
    end else if (stall) begin
      act = ACT_STALL;
    end else begin
      act = ACT_LOAD;
    end
    return act;
  endfunction

endpackage

// File: rtl/id_ex_pipeline_reg_sat_counter.sv
// Saturating event counter with synchronous active-high reset; holds at all-ones.
module sat_counter #(
  parameter int CNT_BITS = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                inc,
  output logic [CNT_BITS-1:0] count
);

  localparam logic [CNT_BITS-1:0] CNT_MAX = {CNT_BITS{1'b1}};
  localparam logic [CNT_BITS-1:0] CNT_ONE = {{(CNT_BITS-1){1'b0}}, 1'b1};

  logic [CNT_BITS-1:0] count_r;

  // Count qualifying cycles, sticking at the maximum instead of wrapping
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= {CNT_BITS{1'b0}};
    end else if (inc && (count_r != CNT_MAX)) begin
      count_r <= count_r + CNT_ONE;
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/id_ex_pipeline_reg.sv
// ID/EX pipeline register: decode-stage fields and control bundle into execute,
// with freeze, flush (bubble), stall (hold) and saturating stall/flush counters.
module id_ex_pipeline_reg
  import id_ex_pipeline_reg_pkg::*;
#(
  parameter int NBITS     = 32,
  parameter int RNBITS    = 5,
  parameter int CTRL_BITS = CTRL_BITS_DEF,
  parameter int CNT_BITS  = 16
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_enable,
  input  logic                 i_stall,
  input  logic                 i_flush,
  input  logic                 i_valid,
  input  logic [CTRL_BITS-1:0] i_ctrl,
  input  logic [NBITS-1:0]     i_pc4,
  input  logic [NBITS-1:0]     i_instruction,
  input  logic [NBITS-1:0]     i_registro1,
  input  logic [NBITS-1:0]     i_registro2,
  input  logic [NBITS-1:0]     i_extension,
  input  logic [RNBITS-1:0]    i_rs,
  input  logic [RNBITS-1:0]    i_rt,
  input  logic [RNBITS-1:0]    i_rd,
  output logic                 o_valid,
  output logic [CTRL_BITS-1:0] o_ctrl,
  output logic [NBITS-1:0]     o_pc4,
  output logic [NBITS-1:0]     o_instruction,
  output logic [NBITS-1:0]     o_registro1,
  output logic [NBITS-1:0]     o_registro2,
  output logic [NBITS-1:0]     o_extension,
  output logic [RNBITS-1:0]    o_rs,
  output logic [RNBITS-1:0]    o_rt,
  output logic [RNBITS-1:0]    o_rd,
  output logic [CNT_BITS-1:0]  o_stall_count,
  output logic [CNT_BITS-1:0]  o_flush_count
);

  id_ex_action_e        action_s;
  logic                 stall_inc_s;
  logic                 flush_inc_s;
  logic                 valid_r;
  logic [CTRL_BITS-1:0] ctrl_r;
  logic [NBITS-1:0]     pc4_r;
  logic [NBITS-1:0]     instruction_r;
  logic [NBITS-1:0]     registro1_r;
  logic [NBITS-1:0]     registro2_r;
  logic [NBITS-1:0]     extension_r;
  logic [RNBITS-1:0]    rs_r;
  logic [RNBITS-1:0]    rt_r;
  logic [RNBITS-1:0]    rd_r;

  // Resolve this cycle's action and the counter increment strobes
  always_comb begin
    action_s    = select_action(i_enable, i_flush, i_stall);
    stall_inc_s = 1'b0;
    flush_inc_s = 1'b0;
    case (action_s)
      ACT_FLUSH: flush_inc_s = 1'b1;
      ACT_STALL: stall_inc_s = 1'b1;
      default: begin
        stall_inc_s = 1'b0;
        flush_inc_s = 1'b0;
      end
    endcase
  end

  // Pipeline register; a flush clears only valid/control so the bubble is inert
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      valid_r       <= 1'b0;
      ctrl_r        <= {CTRL_BITS{1'b0}};
      pc4_r         <= {NBITS{1'b0}};
      instruction_r <= {NBITS{1'b0}};
      registro1_r   <= {NBITS{1'b0}};
      registro2_r   <= {NBITS{1'b0}};
      extension_r   <= {NBITS{1'b0}};
      rs_r          <= {RNBITS{1'b0}};
      rt_r          <= {RNBITS{1'b0}};
      rd_r          <= {RNBITS{1'b0}};
    end else begin
      case (action_s)
        ACT_LOAD: begin
          valid_r       <= i_valid;
          ctrl_r        <= i_valid ? i_ctrl : {CTRL_BITS{1'b0}};
          pc4_r         <= i_pc4;
          instruction_r <= i_instruction;
          registro1_r   <= i_registro1;
          registro2_r   <= i_registro2;
          extension_r   <= i_extension;
          rs_r          <= i_rs;
          rt_r          <= i_rt;
          rd_r          <= i_rd;
        end
        ACT_FLUSH: begin
          valid_r <= 1'b0;
          ctrl_r  <= {CTRL_BITS{1'b0}};
        end
        default: begin
          valid_r <= valid_r;
          ctrl_r  <= ctrl_r;
        end
      endcase
    end
  end

  sat_counter #(.CNT_BITS(CNT_BITS)) u_stall_cnt (
    .clk   (i_clk),
    .reset (i_reset),
    .inc   (stall_inc_s),
    .count (o_stall_count)
  );

  sat_counter #(.CNT_BITS(CNT_BITS)) u_flush_cnt (
    .clk   (i_clk),
    .reset (i_reset),
    .inc   (flush_inc_s),
    .count (o_flush_count)
  );

  assign o_valid       = valid_r;
  assign o_ctrl        = ctrl_r;
  assign o_pc4         = pc4_r;
  assign o_instruction = instruction_r;
  assign o_registro1   = registro1_r;
  assign o_registro2   = registro2_r;
  assign o_extension   = extension_r;
  assign o_rs          = rs_r;
  assign o_rt          = rt_r;
  assign o_rd          = rd_r;

endmodule

// File: tb/tb_id_ex_pipeline_reg.sv
// Scoreboard bench for id_ex_pipeline_reg: a default instance plus a CNT_BITS=3
// instance sharing inputs, checked against a behavioural next-state model.
module tb_id_ex_pipeline_reg;

  logic        i_clk;
  logic        i_reset;
  logic        i_enable;
  logic        i_stall;
  logic        i_flush;
  logic        i_valid;
  logic [15:0] i_ctrl;
  logic [31:0] i_pc4, i_instruction, i_registro1, i_registro2, i_extension;
  logic [4:0]  i_rs, i_rt, i_rd;

  logic        o_valid;
  logic [15:0] o_ctrl;
  logic [31:0] o_pc4, o_instruction, o_registro1, o_registro2, o_extension;
  logic [4:0]  o_rs, o_rt, o_rd;
  logic [15:0] o_stall_count, o_flush_count;

  logic        s_valid;
  logic [15:0] s_ctrl;
  logic [31:0] s_pc4, s_instruction, s_registro1, s_registro2, s_extension;
  logic [4:0]  s_rs, s_rt, s_rd;
  logic [2:0]  s_stall_count, s_flush_count;

  id_ex_pipeline_reg dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_enable(i_enable), .i_stall(i_stall),
    .i_flush(i_flush), .i_valid(i_valid), .i_ctrl(i_ctrl), .i_pc4(i_pc4),
    .i_instruction(i_instruction), .i_registro1(i_registro1),
    .i_registro2(i_registro2), .i_extension(i_extension),
    .i_rs(i_rs), .i_rt(i_rt), .i_rd(i_rd),
    .o_valid(o_valid), .o_ctrl(o_ctrl), .o_pc4(o_pc4),
    .o_instruction(o_instruction), .o_registro1(o_registro1),
    .o_registro2(o_registro2), .o_extension(o_extension),
    .o_rs(o_rs), .o_rt(o_rt), .o_rd(o_rd),
    .o_stall_count(o_stall_count), .o_flush_count(o_flush_count)
  );

  id_ex_pipeline_reg #(.CNT_BITS(3)) dut_sat (
    .i_clk(i_clk), .i_reset(i_reset), .i_enable(i_enable), .i_stall(i_stall),
    .i_flush(i_flush), .i_valid(i_valid), .i_ctrl(i_ctrl), .i_pc4(i_pc4),
    .i_instruction(i_instruction), .i_registro1(i_registro1),
    .i_registro2(i_registro2), .i_extension(i_extension),
    .i_rs(i_rs), .i_rt(i_rt), .i_rd(i_rd),
    .o_valid(s_valid), .o_ctrl(s_ctrl), .o_pc4(s_pc4),
    .o_instruction(s_instruction), .o_registro1(s_registro1),
    .o_registro2(s_registro2), .o_extension(s_extension),
    .o_rs(s_rs), .o_rt(s_rt), .o_rd(s_rd),
    .o_stall_count(s_stall_count), .o_flush_count(s_flush_count)
  );

  typedef struct packed {
    logic        valid;
    logic [15:0] ctrl;
    logic [31:0] pc4, instruction, registro1, registro2, extension;
    logic [4:0]  rs, rt, rd;
    logic [15:0] stall_cnt, flush_cnt;
    logic [2:0]  stall_cnt3, flush_cnt3;
  } exp_t;

  exp_t exp_q[$];
  exp_t m;
  int   assert_count;
  int   fail_count;

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    assert_count++;
    if (obs !== exp) begin
      fail_count++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] sat16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [2:0] sat3(input logic [2:0] v);
    return (v == 3'd7) ? v : v + 3'd1;
  endfunction

  // Set control inputs; datapath fields get fresh random values every call
  task automatic drive(input logic rst, input logic en, input logic st,
                       input logic fl, input logic vd, input logic [15:0] ctrl);
    i_reset = rst; i_enable = en; i_stall = st; i_flush = fl;
    i_valid = vd;  i_ctrl = ctrl;
    i_pc4 = $urandom; i_instruction = $urandom; i_registro1 = $urandom;
    i_registro2 = $urandom; i_extension = $urandom;
    i_rs = 5'($urandom); i_rt = 5'($urandom); i_rd = 5'($urandom);
  endtask

  // Advance the model, push the expectation, clock once, pop and compare
  task automatic step();
    exp_t e;
    if (i_reset) begin
      m = '0;
    end else if (!i_enable) begin
      m = m;
    end else if (i_flush) begin
      m.valid = 1'b0; m.ctrl = 16'h0000;
      m.flush_cnt = sat16(m.flush_cnt); m.flush_cnt3 = sat3(m.flush_cnt3);
    end else if (i_stall) begin
      m.stall_cnt = sat16(m.stall_cnt); m.stall_cnt3 = sat3(m.stall_cnt3);
    end else begin
      m.valid = i_valid; m.ctrl = i_valid ? i_ctrl : 16'h0000;
      m.pc4 = i_pc4; m.instruction = i_instruction; m.registro1 = i_registro1;
      m.registro2 = i_registro2; m.extension = i_extension;
      m.rs = i_rs; m.rt = i_rt; m.rd = i_rd;
    end
    exp_q.push_back(m);
    @(posedge i_clk);
    #1;
    e = exp_q.pop_front();
    check_eq("valid",       64'(o_valid),       64'(e.valid));
    check_eq("ctrl",        64'(o_ctrl),        64'(e.ctrl));
    check_eq("pc4",         64'(o_pc4),         64'(e.pc4));
    check_eq("instruction", 64'(o_instruction), 64'(e.instruction));
    check_eq("registro1",   64'(o_registro1),   64'(e.registro1));
    check_eq("registro2",   64'(o_registro2),   64'(e.registro2));
    check_eq("extension",   64'(o_extension),   64'(e.extension));
    check_eq("rs",          64'(o_rs),          64'(e.rs));
    check_eq("rt",          64'(o_rt),          64'(e.rt));
    check_eq("rd",          64'(o_rd),          64'(e.rd));
    check_eq("stall_count", 64'(o_stall_count), 64'(e.stall_cnt));
    check_eq("flush_count", 64'(o_flush_count), 64'(e.flush_cnt));
    check_eq("stall_cnt3",  64'(s_stall_count), 64'(e.stall_cnt3));
    check_eq("flush_cnt3",  64'(s_flush_count), 64'(e.flush_cnt3));
    check_eq("bubble_ctrl", 64'((!o_valid) && (o_ctrl != 16'h0000)), 64'(0));
  endtask

  initial begin
    assert_count = 0;
    fail_count   = 0;
    m            = '0;

    // Reset, then the reference load
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h5A5A); step();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h5A5A); step();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h00A5);
    i_pc4 = 32'h0000_0008; i_rt = 5'd9; step();
    check_eq("load_pc4_lit", 64'(o_pc4), 64'h8);
    check_eq("load_ctrl_lit", 64'(o_ctrl), 64'h00A5);
    check_eq("load_rt_lit", 64'(o_rt), 64'd9);

    // Three stall cycles with changing inputs, then load resumes
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'(i + 16'h0100)); step();
    end
    check_eq("stall3_lit", 64'(o_stall_count), 64'd3);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0033); step();

    // Flush with simultaneous stall and all-ones control
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 16'hFFFF); step();
    check_eq("flush_lit", 64'(o_flush_count), 64'd1);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0042); step();

    // Frozen with flush requested, then a single-step enable pulse
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0F0F); step();
    end
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0F0F); step();
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0F0F); step();

    // Upstream bubble: control zeroed, datapath still captured
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h1234); step();

    // Reset while frozen takes effect at once
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0001); step();

    // Random mix of all controls
    for (int i = 0; i < 40; i++) begin
      drive(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 2) == 0), ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 3) != 0), 16'($urandom));
      step();
    end

    // Saturation of the narrow counter, then reset mid-stall
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0000); step();
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'($urandom)); step();
    end
    check_eq("sat3_lit", 64'(s_stall_count), 64'd7);
    check_eq("stall10_lit", 64'(o_stall_count), 64'd10);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'h00FF); step();
    check_eq("rst_mid_stall", 64'(s_stall_count), 64'd0);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h00FF); step();

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule

// File: doc/id_ex_pipeline_reg.md
# id_ex_pipeline_reg

Parametrised ID/EX pipeline register for the MIPS core, between the decode stage (register file, sign extension, control unit) and the execute stage (ALU, forwarding muxes). Carries the datapath fields, the control-signal bundle, register specifiers and a valid bit. Supports hazard-unit stall (hold) and flush (bubble insertion), debug-unit gating through an enable, and saturating stall/flush event counters that the debug unit reads.

## Interface
Parameters:
- NBITS, 32, datapath width (PC+4, instruction, operands, extension)
- RNBITS, 5, register specifier width
- CTRL_BITS, 16, width of the decoded control bundle
- CNT_BITS, 16, width of each event counter

Ports:
- i_clk  in  1  clock, all state updates on rising edge
- i_reset  in  1  synchronous, active-high reset
- i_enable  in  1  debug-unit gate; low freezes the block entirely
- i_stall  in  1  hazard unit: hold current contents
- i_flush  in  1  hazard unit: insert bubble
- i_valid  in  1  decode stage holds a real instruction
- i_ctrl  in  CTRL_BITS  decoded control bundle
- i_pc4, i_instruction, i_registro1, i_registro2, i_extension  in  NBITS each  datapath fields
- i_rs, i_rt, i_rd  in  RNBITS each  register specifiers
- o_valid  out  1  registered valid
- o_ctrl  out  CTRL_BITS  registered control bundle, zero whenever o_valid=0
- o_pc4, o_instruction, o_registro1, o_registro2, o_extension  out  NBITS each
- o_rs, o_rt, o_rd  out  RNBITS each
- o_stall_count  out  CNT_BITS  saturating count of stall cycles
- o_flush_count  out  CNT_BITS  saturating count of flush cycles

## Operation
- Per-cycle action, strict priority: reset > freeze (i_enable=0) > flush > stall > load.
- Reset: every output register, including counters, cleared to 0.
- Freeze: all registers and counters hold; i_stall/i_flush ignored.
- Flush: o_valid<=0, o_ctrl<=0; datapath fields and specifiers hold their previous values; o_flush_count increments. Flush overrides a simultaneous stall (stall count not incremented).
- Stall: all fields hold; o_stall_count increments.
- Load: all fields capture inputs; o_valid<=i_valid; o_ctrl<=i_valid ? i_ctrl : 0 (upstream bubble propagates as zero control).
- Invariant: o_valid=0 implies o_ctrl=0, so a bubble never writes registers or memory.
- Counters saturate at 2^CNT_BITS-1; no wrap.
- No combinational path from any input to any output.

## Timing
- Latency 1 cycle: values presented at edge N appear on outputs after edge N.
- All outputs 0 in the cycle following a reset edge; reset asserted mid-stall or mid-freeze takes effect at that same edge.
- Stall of k consecutive cycles: outputs constant for k cycles; stall count +k (saturating).
- i_enable deassert/assert is glitch-free at cycle granularity: one enabled cycle advances exactly one step (debug single-step).
- Counters are readable every cycle; an increment is visible the cycle after the qualifying edge.

## Structure
- Shared package: control-bundle field offsets (RegWrite, MemRead, MemWrite, MemToReg, ALUSrc, RegDst, ALUOp, Branch) and CTRL_BITS default, shared with the control unit and EX/MEM register.
- One natural sub-module: sat_counter (parameter CNT_BITS; inputs clk, reset, inc; output count), instantiated twice.

## Test plan
- Reset then load: after reset all outputs 0; drive i_valid=1, i_pc4=0x00000008, i_ctrl=0x00A5, i_rt=5'd9 -> next cycle o_pc4=0x00000008, o_ctrl=0x00A5, o_rt=9, o_valid=1.
- Stall 3 cycles with changing inputs -> outputs unchanged for 3 cycles, o_stall_count=3, then load resumes on the 4th.
- Flush and stall together with i_ctrl=0xFFFF -> o_valid=0, o_ctrl=0, o_flush_count=1, o_stall_count unchanged, datapath fields keep prior values.
- i_enable=0 for 5 cycles with i_flush=1 -> nothing changes, counters unchanged; one i_enable pulse -> single flush, o_flush_count+1.
- Upstream bubble i_valid=0, i_ctrl=0x1234 -> o_valid=0, o_ctrl=0, o_registro1 still captures input.
- CNT_BITS=3, 10 stall cycles -> o_stall_count reaches 7 and stays 7; reset asserted mid-stall -> counter 0 next cycle.
